// File: rtl/sram_burst_ctrl.sv
// sram_burst_ctrl: initiator-side burst controller for a single-port SRAM macro with
// active-low csb0/web0, negedge write commit and combinational read data.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_write       burst command handshake (accepted only in idle)
//   cmd_addr, cmd_len                   burst start address and beat count (0..RAM_DEPTH)
//   wdata_valid/wdata_ready/wdata       write-beat stream
//   rdata_valid/rdata_ready/rdata       read-beat stream from a 2-entry response FIFO
//   rdata_last                          marks the final beat of a read burst
//   done                                one-cycle burst-complete pulse
//   busy                                controller not idle
//   csb0, web0, addr0, din0             registered SRAM port outputs
//   dout0                               SRAM read data, valid during a read cycle
module sram_burst_ctrl #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_last,
  output logic                  done,
  output logic                  busy,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CntOne   = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {StIdle, StWr, StRd, StFin} state_e;

  state_e r_state, w_state_nxt;

  // Burst bookkeeping: r_cnt counts accepted write beats or issued read beats.
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic [ADDR_WIDTH-1:0] r_cur_addr;

  // SRAM port registers plus a tag describing the read currently on the port.
  logic                  r_csb0;
  logic                  r_web0;
  logic [ADDR_WIDTH-1:0] r_addr0;
  logic [DATA_WIDTH-1:0] r_din0;
  logic                  r_rd_inflight;
  logic                  r_rd_last;

  // 2-entry response FIFO.
  logic [DATA_WIDTH-1:0] r_fifo_data [2];
  logic [1:0]            r_fifo_last;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  logic                  w_cmd_hs;
  logic                  w_wr_hs;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_rd_issue;
  logic                  w_issue_last;
  logic [ADDR_WIDTH-1:0] w_issue_addr;
  logic [ADDR_WIDTH:0]   w_cnt_base;
  logic [2:0]            w_occ;

  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    return (a == LastAddr) ? '0 : a + AddrOne;
  endfunction

  assign w_cmd_hs    = cmd_valid && cmd_ready;
  assign w_wr_hs     = wdata_valid && wdata_ready;
  assign rdata_valid = (r_count != 2'd0);
  assign w_pop       = rdata_valid && rdata_ready;
  // A read on the port this cycle lands in the FIFO at the closing posedge.
  assign w_push      = r_rd_inflight;
  // Slots committed after this edge: stored beats not leaving now, plus the read in flight.
  assign w_occ       = {1'b0, r_count} + {2'b00, r_rd_inflight} - {2'b00, w_pop};
  assign w_cnt_base  = (r_state == StIdle) ? '0 : r_cnt;

  assign rdata      = r_fifo_data[r_rd_ptr];
  assign rdata_last = rdata_valid && r_fifo_last[r_rd_ptr];
  assign busy       = (r_state != StIdle);
  assign csb0       = r_csb0;
  assign web0       = r_web0;
  assign addr0      = r_addr0;
  assign din0       = r_din0;

  always_comb begin
    w_state_nxt  = r_state;
    cmd_ready    = 1'b0;
    wdata_ready  = 1'b0;
    done         = 1'b0;
    w_rd_issue   = 1'b0;
    w_issue_last = 1'b0;
    w_issue_addr = r_cur_addr;
    case (r_state)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            w_state_nxt = StFin;
          end else if (cmd_write) begin
            w_state_nxt = StWr;
          end else begin
            // First read goes out on the handshake edge to reach 2-cycle latency.
            w_state_nxt  = StRd;
            w_rd_issue   = 1'b1;
            w_issue_addr = cmd_addr;
            w_issue_last = (cmd_len == CntOne);
          end
        end
      end
      StWr: begin
        wdata_ready = (r_cnt < r_len);
        // Once every beat is accepted, the final write is on the port this cycle.
        if (r_cnt == r_len) begin
          done        = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      StRd: begin
        if ((r_cnt < r_len) && (w_occ < 3'd2)) begin
          w_rd_issue   = 1'b1;
          w_issue_last = ((r_cnt + CntOne) == r_len);
        end
        if (w_pop && r_fifo_last[r_rd_ptr]) begin
          done        = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      StFin: begin
        done        = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_cnt      <= '0;
      r_cur_addr <= '0;
    end else begin
      if (w_cmd_hs) begin
        r_len <= cmd_len;
      end
      if (w_rd_issue || w_wr_hs) begin
        r_cnt      <= w_cnt_base + CntOne;
        r_cur_addr <= addr_inc(w_issue_addr);
      end else if (w_cmd_hs) begin
        r_cnt      <= '0;
        r_cur_addr <= cmd_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csb0        <= 1'b1;
      r_web0        <= 1'b1;
      r_addr0       <= '0;
      r_din0        <= '0;
      r_rd_inflight <= 1'b0;
      r_rd_last     <= 1'b0;
    end else begin
      r_rd_inflight <= w_rd_issue;
      r_rd_last     <= w_issue_last;
      if (w_wr_hs) begin
        r_csb0  <= 1'b0;
        r_web0  <= 1'b0;
        r_addr0 <= r_cur_addr;
        r_din0  <= wdata;
      end else if (w_rd_issue) begin
        r_csb0  <= 1'b0;
        r_web0  <= 1'b1;
        r_addr0 <= w_issue_addr;
      end else begin
        r_csb0 <= 1'b1;
        r_web0 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_last    <= '0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_count        <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= dout0;
        r_fifo_last[r_wr_ptr] <= r_rd_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/sram_burst_ctrl.md
Name: sram_burst_ctrl

Overview:
- Initiator-side controller for the single-port 64x32 SRAM macro (active-low csb0/web0, negedge write, combinational read).
- Turns burst commands plus a write-data stream into registered SRAM port cycles.
- Returns read bursts on a valid/ready stream through a 2-entry response FIFO.
- Sits between the HDC datapath (hypervector load/store) and each SRAM instance.

Parameters:
DATA_WIDTH, 64, SRAM word width and width of wdata/rdata
ADDR_WIDTH, 5, SRAM address width
RAM_DEPTH, 1<<ADDR_WIDTH, words in SRAM; addresses wrap modulo this value

Ports:
clk  in  1  clock; all state and SRAM-side outputs update on posedge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  burst command valid
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_WIDTH  burst start address
cmd_len  in  ADDR_WIDTH+1  beats in burst, 0..RAM_DEPTH
wdata_valid  in  1  write beat valid
wdata_ready  out  1  write beat accepted when both high
wdata  in  DATA_WIDTH  write beat
rdata_valid  out  1  read beat valid (FIFO non-empty)
rdata_ready  in  1  read beat consumer ready
rdata  out  DATA_WIDTH  FIFO head
rdata_last  out  1  high with final beat of read burst
done  out  1  one-cycle burst-complete pulse
busy  out  1  state != IDLE
csb0  out  1  SRAM chip select, active low, registered
web0  out  1  SRAM write enable, active low, registered
addr0  out  ADDR_WIDTH  SRAM address, registered
din0  out  DATA_WIDTH  SRAM write data, registered
dout0  in  DATA_WIDTH  SRAM read data, valid during a read cycle

Behaviour:
- Reset (async, immediate on rst_n low): state IDLE; csb0=1, web0=1, addr0=0, din0=0; FIFO empty; rdata_valid=0, rdata_last=0, done=0, busy=0, wdata_ready=0; counters 0. A reset mid-burst aborts it, issues no SRAM access, and discards FIFO contents.
- States: IDLE, WR, RD, FIN.
- IDLE: cmd_ready=1. On handshake, latch addr/len/write. len=0 goes to FIN; else WR or RD.
- Every cycle with no access issued: csb0=1, web0=1. addr0/din0 hold their last values.
- WR: wdata_ready=1 while beats_accepted < len. On each wdata handshake, the next posedge loads csb0=0, web0=0, addr0=cur_addr, din0=wdata. SRAM commits at that cycle's negedge. cur_addr increments mod RAM_DEPTH.
- WR done: pulses in the cycle the last write is on the port; state returns to IDLE on the following posedge. wdata_valid gaps insert idle port cycles.
- RD issue rule: issue while issued < len and (fifo_count - pop + inflight) < 2. pop = rdata_valid && rdata_ready. inflight = a read currently on the port. Issue loads csb0=0, web0=1, addr0=cur_addr at the next posedge.
- RD capture: dout0 is captured into the FIFO at the posedge ending the read cycle.
- Read latency: first rdata_valid is 2 cycles after the cmd handshake. Throughput is 1 beat/cycle with rdata_ready held high. Backpressure never loses or duplicates data.
- RD completion: rdata_last accompanies beat len-1. done pulses in the cycle that beat handshakes; state returns to IDLE on the next posedge.
- FIN (len=0): done pulses for one cycle, no SRAM access, then IDLE.
- cmd_valid outside IDLE is ignored (cmd_ready=0). wdata_valid outside WR is ignored. wdata_ready never asserts in RD.
- Address wrap: cmd_addr+len > RAM_DEPTH wraps (e.g. addr 30, len 4 -> 30,31,0,1).
- Never csb0=0 with web0=0 except on an accepted wdata beat. SRAM outputs are glitch-free (flop outputs).

Test Plan:
- Write addr 0 len 32, wdata = 64'hA5A5_0000_0000_0000+i, no gaps -> 32 consecutive cycles csb0=0, web0=0, addr0=0..31; done on the 32nd cycle; SRAM model contents match.
- Read addr 0 len 32 after previous test, rdata_ready=1 -> first rdata_valid 2 cycles after cmd handshake; 32 back-to-back beats equal to written data; rdata_last and done on beat 31.
- Read addr 4 len 8, rdata_ready toggling 1,0,0,1 pattern -> exactly 8 beats in address order; at most 2 reads ahead of consumer; no csb0=0 while FIFO+inflight=2.
- Write addr 30 len 4, then read addr 30 len 4 -> accesses at 30,31,0,1; data round-trips correctly.
- cmd_len=0 write -> no csb0 assertion, done pulses 1 cycle after handshake, cmd_ready back high the next cycle.
- rst_n low for one cycle during beat 3 of a len-8 read -> immediately csb0=1, web0=1, rdata_valid=0, busy=0. Subsequent read len 2 at addr 0 completes normally.
